// File: rtl/fbuff_pkg.sv
// -----------------------------------------------------------------------------
// fbuff_pkg
// Shared types and constants for the framebuffer write path.
//   FB_ADDR_W / FB_DATA_W / FB_BE_W : default framebuffer word geometry
//   fb_write_t                      : one framebuffer write (address, data, BE),
//                                     used by line fillers and the write arbiter
//   out_state_e                     : occupancy of the arbiter output register
//   idx_width()                     : bits needed to index N requesters (>= 1)
// -----------------------------------------------------------------------------
package fbuff_pkg;

  localparam int FB_ADDR_W = 16;
  localparam int FB_DATA_W = 32;
  localparam int FB_BE_W   = FB_DATA_W / 8;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] address;
    logic [FB_DATA_W-1:0] writedata;
    logic [FB_BE_W-1:0]   byteenable;
  } fb_write_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fbuff_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// fbuff_write_arbiter_if
// Bundles the requester-side Avalon-MM write buses (packed, requester i in
// slice i) and the single framebuffer write port.
//   slave  modport : the arbiter's view (takes requests, drives the framebuffer)
//   master modport : the surroundings (requesters plus framebuffer RAM side)
// Requester-side signals:  avs_req_write / address / writedata / byteenable in,
//                          avs_req_waitrequest out (per requester)
// Framebuffer-side signals: avm_fbuff_write / address / writedata / byteenable
//                          out, avm_fbuff_waitrequest in
// -----------------------------------------------------------------------------
interface fbuff_write_arbiter_if
  import fbuff_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = FB_ADDR_W,
  parameter int DATA_W  = FB_DATA_W
);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_REQ-1:0]        avs_req_write;
  logic [NUM_REQ*ADDR_W-1:0] avs_req_address;
  logic [NUM_REQ*DATA_W-1:0] avs_req_writedata;
  logic [NUM_REQ*BE_W-1:0]   avs_req_byteenable;
  logic [NUM_REQ-1:0]        avs_req_waitrequest;

  logic                      avm_fbuff_write;
  logic [ADDR_W-1:0]         avm_fbuff_address;
  logic [DATA_W-1:0]         avm_fbuff_writedata;
  logic [BE_W-1:0]           avm_fbuff_byteenable;
  logic                      avm_fbuff_waitrequest;

  modport slave (
    input  avs_req_write, avs_req_address, avs_req_writedata, avs_req_byteenable,
    output avs_req_waitrequest,
    output avm_fbuff_write, avm_fbuff_address, avm_fbuff_writedata,
           avm_fbuff_byteenable,
    input  avm_fbuff_waitrequest
  );

  modport master (
    output avs_req_write, avs_req_address, avs_req_writedata, avs_req_byteenable,
    input  avs_req_waitrequest,
    input  avm_fbuff_write, avm_fbuff_address, avm_fbuff_writedata,
           avm_fbuff_byteenable,
    output avm_fbuff_waitrequest
  );

endinterface

// File: rtl/fbuff_write_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker.
//   req         : per-requester request vector
//   rr_ptr      : requester with the highest round-robin priority this cycle
//   prio_mask   : requesters that win outright whenever they request
//                 (lowest index first); all-zero gives plain round-robin
//   grant_valid : some requester is granted
//   grant       : index of the granted requester
// -----------------------------------------------------------------------------
module rr_pick
  import fbuff_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  input  logic [NUM_REQ-1:0] prio_mask,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant
);

  logic [NUM_REQ-1:0] prio_hit;
  int                 idx;

  assign prio_hit = req & prio_mask;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path through the block leaves it unassigned (which would infer a latch).
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    if (|prio_hit) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant_valid && prio_hit[k]) begin
          grant_valid = 1'b1;
          grant       = IDX_W'(k);
        end
      end
    end else begin
      // Walk from rr_ptr upward; rr_ptr < NUM_REQ, so one subtraction wraps.
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!grant_valid && req[idx]) begin
          grant_valid = 1'b1;
          grant       = IDX_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/fbuff_write_arbiter.sv
// -----------------------------------------------------------------------------
// fbuff_write_arbiter
// Shares the framebuffer write port between NUM_REQ Avalon-MM write masters
// with round-robin arbitration and one registered output stage.
//   clk, reset : system clock; asynchronous active-high reset
//   bus        : fbuff_write_arbiter_if.slave (requester buses + fbuff port)
// Build option: define FBUFF_ARB_HOST_PRIORITY_EN to make requester 0 (host
// write-through) win whenever it requests; requesters 1..NUM_REQ-1 then share
// the round-robin among themselves.
// -----------------------------------------------------------------------------
module fbuff_write_arbiter
  import fbuff_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = FB_ADDR_W,
  parameter int DATA_W  = FB_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  fbuff_write_arbiter_if.slave  bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = idx_width(NUM_REQ);

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
  } wr_t;

  out_state_e         state_q, state_d;
  wr_t                out_q, sel;
  logic [IDX_W-1:0]   rr_ptr, grant;
  logic [NUM_REQ-1:0] prio_mask;
  logic               grant_valid, can_accept, accept, advance_ptr;
  int                 sel_idx;

`ifdef FBUFF_ARB_HOST_PRIORITY_EN
  assign prio_mask   = NUM_REQ'(1);
  // Host grants do not move the pointer, so fillers keep their rotation.
  assign advance_ptr = accept && (grant != '0);
`else
  assign prio_mask   = '0;
  assign advance_ptr = accept;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req         (bus.avs_req_write),
    .rr_ptr      (rr_ptr),
    .prio_mask   (prio_mask),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // A full register that drains this cycle can be refilled in the same cycle.
  assign can_accept = (state_q == OUT_EMPTY) || !bus.avm_fbuff_waitrequest;
  assign accept     = can_accept && grant_valid;

  // Only the granted slice is read, so X on idle requesters never propagates.
  always_comb begin
    sel_idx        = int'(grant);
    sel.address    = bus.avs_req_address[sel_idx*ADDR_W +: ADDR_W];
    sel.writedata  = bus.avs_req_writedata[sel_idx*DATA_W +: DATA_W];
    sel.byteenable = bus.avs_req_byteenable[sel_idx*BE_W +: BE_W];
  end

  always_comb begin
    bus.avs_req_waitrequest = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.avs_req_waitrequest[i] = reset || !(accept && (grant == IDX_W'(i)));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (accept) state_d = OUT_FULL;
      OUT_FULL:  if (!bus.avm_fbuff_waitrequest) state_d = accept ? OUT_FULL : OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) state_q <= OUT_EMPTY;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the output data register is reset on purpose; the framebuffer side
    // must see all-zero fields, not stale data, straight out of reset.
    if (reset)       out_q <= '0;
    else if (accept) out_q <= sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (advance_ptr) begin
      rr_ptr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
    end
  end

  assign bus.avm_fbuff_write      = (state_q == OUT_FULL);
  assign bus.avm_fbuff_address    = out_q.address;
  assign bus.avm_fbuff_writedata  = out_q.writedata;
  assign bus.avm_fbuff_byteenable = out_q.byteenable;

endmodule
